// File: rtl/bus_arbiter_if.sv
// Bundles the two requester ports and the shared-bus side of bus_arbiter.
// The arbiter connects through the slave modport; the requesters and bus model use master.
interface bus_arbiter_if #(
    parameter int DW = 32
);
    logic          i_req0;
    logic          i_req1;
    logic          i_we0;
    logic          i_we1;
    logic [DW-1:0] i_addr0;
    logic [DW-1:0] i_addr1;
    logic [DW-1:0] i_wdata0;
    logic [DW-1:0] i_wdata1;
    logic          o_done0;
    logic          o_done1;
    logic          o_err0;
    logic          o_err1;
    logic [DW-1:0] o_rdata;
    logic          o_bus_req;
    logic          o_bus_we;
    logic [DW-1:0] o_bus_addr;
    logic [DW-1:0] o_bus_data;
    logic [DW-1:0] i_bus_data;
    logic          i_bus_data_ready;
    logic          o_owner;
    logic          o_busy;

    modport slave (
        input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
        input  i_bus_data, i_bus_data_ready,
        output o_done0, o_done1, o_err0, o_err1, o_rdata,
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_data, o_owner, o_busy
    );

    modport master (
        output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
        output i_bus_data, i_bus_data_ready,
        input  o_done0, o_done1, o_err0, o_err1, o_rdata,
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_data, o_owner, o_busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter for a shared bus with a bounded wait and timeout.
// All outputs come straight from registers; the FSM computes their next values.
module bus_arbiter #(
    parameter int DW       = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter value seen on the MAX_WAIT-th ACCESS cycle (counter starts at 0).
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t        state_r, state_s;
    logic [7:0]    wait_r, wait_s;
    logic          owner_r, owner_s;
    logic          last_r, last_s;
    logic          win_s;
    logic          busy_r, busy_s;
    logic          bus_req_r, bus_req_s;
    logic          bus_we_r, bus_we_s;
    logic [DW-1:0] bus_addr_r, bus_addr_s;
    logic [DW-1:0] bus_data_r, bus_data_s;
    logic [DW-1:0] rdata_r, rdata_s;
    logic          done0_r, done0_s;
    logic          done1_r, done1_s;
    logic          err0_r, err0_s;
    logic          err1_r, err1_s;

    // State and output registers; reset clears everything and parks the pointer on port 1.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r    <= IDLE;
            wait_r     <= 8'd0;
            owner_r    <= 1'b0;
            last_r     <= 1'b1;
            busy_r     <= 1'b0;
            bus_req_r  <= 1'b0;
            bus_we_r   <= 1'b0;
            bus_addr_r <= {DW{1'b0}};
            bus_data_r <= {DW{1'b0}};
            rdata_r    <= {DW{1'b0}};
            done0_r    <= 1'b0;
            done1_r    <= 1'b0;
            err0_r     <= 1'b0;
            err1_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_r     <= wait_s;
            owner_r    <= owner_s;
            last_r     <= last_s;
            busy_r     <= busy_s;
            bus_req_r  <= bus_req_s;
            bus_we_r   <= bus_we_s;
            bus_addr_r <= bus_addr_s;
            bus_data_r <= bus_data_s;
            rdata_r    <= rdata_s;
            done0_r    <= done0_s;
            done1_r    <= done1_s;
            err0_r     <= err0_s;
            err1_r     <= err1_s;
        end
    end

    // Next-state logic: arbitration in IDLE, wait/timeout tracking in ACCESS, pointer update in DONE.
    always_comb begin
        state_s    = state_r;
        wait_s     = wait_r;
        owner_s    = owner_r;
        last_s     = last_r;
        win_s      = 1'b0;
        bus_req_s  = bus_req_r;
        bus_we_s   = bus_we_r;
        bus_addr_s = bus_addr_r;
        bus_data_s = bus_data_r;
        rdata_s    = rdata_r;
        done0_s    = 1'b0;
        done1_s    = 1'b0;
        err0_s     = 1'b0;
        err1_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.i_req0 && bus.i_req1) begin
                    win_s = ~last_r;
                end else if (bus.i_req1) begin
                    win_s = 1'b1;
                end else begin
                    win_s = 1'b0;
                end
                if (bus.i_req0 || bus.i_req1) begin
                    state_s    = ACCESS;
                    wait_s     = 8'd0;
                    owner_s    = win_s;
                    bus_req_s  = 1'b1;
                    bus_we_s   = win_s ? bus.i_we1    : bus.i_we0;
                    bus_addr_s = win_s ? bus.i_addr1  : bus.i_addr0;
                    bus_data_s = win_s ? bus.i_wdata1 : bus.i_wdata0;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                // Ready on the last permitted cycle still wins over the timeout.
                if (bus.i_bus_data_ready || (wait_r == WAIT_LAST)) begin
                    state_s    = DONE;
                    wait_s     = 8'd0;
                    bus_req_s  = 1'b0;
                    bus_we_s   = 1'b0;
                    bus_addr_s = {DW{1'b0}};
                    bus_data_s = {DW{1'b0}};
                    done0_s    = ~owner_r;
                    done1_s    = owner_r;
                    if (bus.i_bus_data_ready) begin
                        rdata_s = bus_we_r ? {DW{1'b0}} : bus.i_bus_data;
                    end else begin
                        rdata_s = {DW{1'b0}};
                        err0_s  = ~owner_r;
                        err1_s  = owner_r;
                    end
                end else begin
                    wait_s = wait_r + 8'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
                last_s  = owner_r;
            end
            default: begin
                state_s    = IDLE;
                wait_s     = 8'd0;
                bus_req_s  = 1'b0;
                bus_we_s   = 1'b0;
                bus_addr_s = {DW{1'b0}};
                bus_data_s = {DW{1'b0}};
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    assign bus.o_done0    = done0_r;
    assign bus.o_done1    = done1_r;
    assign bus.o_err0     = err0_r;
    assign bus.o_err1     = err1_r;
    assign bus.o_rdata    = rdata_r;
    assign bus.o_bus_req  = bus_req_r;
    assign bus.o_bus_we   = bus_we_r;
    assign bus.o_bus_addr = bus_addr_r;
    assign bus.o_bus_data = bus_data_r;
    assign bus.o_owner    = owner_r;
    assign bus.o_busy     = busy_r;

endmodule
